// File: rtl/mul_sweep_pkg.sv
// Shared definitions for the multiplier sweep checker: FSM state encoding,
// maximal-length Galois LFSR tap masks per width, and a saturating increment.
// The tap table is consumed only when MULCHK_LFSR_EN is defined.
package mul_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Right-shifting Galois toggle masks, one maximal-length polynomial per width 2..32
    localparam logic [31:0] LFSR_TAPS [2:32] = '{
        32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
        32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
        32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
        32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
        32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
        32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
        32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
        32'h2000_0029, 32'h4800_0000, 32'h8020_0003
    };

    // Increment that sticks at vmax instead of wrapping
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] vmax);
        return (v >= vmax) ? vmax : v + 64'd1;
    endfunction

endpackage

// File: rtl/mul_sweep_opgen.sv
// Operand generator for one multiplier input: linear stride (mod 2^W) or,
// when MULCHK_LFSR_EN is defined and selected at load, a Galois LFSR.
module mul_sweep_opgen
    import mul_sweep_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_adv,
    input  logic [W-1:0] i_step,
`ifdef MULCHK_LFSR_EN
    input  logic         i_lfsr,
`endif
    output logic [W-1:0] o_op
);

    logic [W-1:0] r_step;
    logic [W-1:0] r_op;
    logic [W-1:0] w_stride;

    assign w_stride = r_op + r_step;

`ifdef MULCHK_LFSR_EN
    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS[W]);

    logic         r_lfsr;
    logic [W-1:0] w_galois;
    logic [W-1:0] w_seed;

    // Forcing bit 0 keeps the seed out of the all-zero lock-up state
    assign w_seed   = i_step | W'(1);
    assign w_galois = r_op[0] ? ((r_op >> 1) ^ TAPS) : (r_op >> 1);

    // Latch step/mode on load, then advance the selected sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_step <= '0;
            r_lfsr <= 1'b0;
        end else if (i_load) begin
            r_step <= i_step;
            r_lfsr <= i_lfsr;
            r_op   <= i_lfsr ? w_seed : '0;
        end else if (i_adv) begin
            r_op <= r_lfsr ? w_galois : w_stride;
        end
    end
`else
    // Latch step on load, then advance by the stride with silent wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_step <= '0;
        end else if (i_load) begin
            r_step <= i_step;
            r_op   <= '0;
        end else if (i_adv) begin
            r_op <= w_stride;
        end
    end
`endif

    assign o_op = r_op;

endmodule

// File: rtl/mul_sweep_checker.sv
// Self-test harness around an external W x W multiplier: sweeps operands,
// compares the product LAT+1 cycles later against a golden product, and
// counts vectors and mismatches. MULCHK_LFSR_EN adds the LFSR operand mode.
module mul_sweep_checker
    import mul_sweep_pkg::*;
#(
    parameter int W      = 12,
    parameter int PW     = 2*W+1,
    parameter int LAT    = 0,
    parameter int NVEC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
`ifdef MULCHK_LFSR_EN
    input  logic              mode,
`endif
    input  logic [NVEC_W-1:0] nvec,
    input  logic [W-1:0]      step_a,
    input  logic [W-1:0]      step_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [PW-1:0]     mul_p,
    output logic              busy,
    output logic              done,
    output logic [NVEC_W-1:0] vec_cnt,
    output logic [NVEC_W-1:0] err_cnt,
    output logic              err_flag,
    output logic [W-1:0]      first_err_a,
    output logic [W-1:0]      first_err_b
);

    localparam logic [63:0] CNT_MAX = (64'd1 << NVEC_W) - 64'd1;

    state_t            r_state;
    state_t            w_next;
    logic              w_load;
    logic              w_adv;
    logic              w_issue;
    logic              w_last;
    logic [NVEC_W-1:0] r_nvec;
    logic [NVEC_W-1:0] r_issued;
    logic [2:0]        r_drain;

    logic [2*W-1:0]    w_prod;
    logic [PW-1:0]     w_gold;
    logic [LAT:0]      r_vld;
    logic [PW-1:0]     r_gold [LAT:0];
    logic [W-1:0]      r_opa  [LAT:0];
    logic [W-1:0]      r_opb  [LAT:0];
    logic [PW-1:0]     r_p;
    logic              w_chk;
    logic              w_mis;

    logic [NVEC_W-1:0] r_vec_cnt;
    logic [NVEC_W-1:0] r_err_cnt;
    logic              r_err_flag;
    logic [W-1:0]      r_fea;
    logic [W-1:0]      r_feb;

    mul_sweep_opgen #(.W(W)) u_gen_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .i_step (step_a),
`ifdef MULCHK_LFSR_EN
        .i_lfsr (mode),
`endif
        .o_op   (mul_a)
    );

    mul_sweep_opgen #(.W(W)) u_gen_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .i_step (step_b),
`ifdef MULCHK_LFSR_EN
        .i_lfsr (mode),
`endif
        .o_op   (mul_b)
    );

    // nvec == 0 means free-run, so the terminal compare must never fire then
    assign w_last = (r_nvec != '0) && ((r_issued + NVEC_W'(1)) == r_nvec);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and per-cycle controls; abort overrides everything else
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_adv   = 1'b0;
        w_issue = 1'b0;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_next = RUN;
                        w_load = 1'b1;
                    end
                end
                RUN: begin
                    w_issue = 1'b1;
                    if (w_last) w_next = DRAIN;
                    else        w_adv  = 1'b1;
                end
                DRAIN: begin
                    if (r_drain == 3'd0) w_next = DONE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Issue counter, latched vector target and drain countdown (LAT..0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nvec   <= '0;
            r_issued <= '0;
            r_drain  <= '0;
        end else begin
            if (w_load) begin
                r_nvec   <= nvec;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + NVEC_W'(1);
            end
            if (r_state == RUN && w_next == DRAIN) r_drain <= 3'(LAT);
            else if (r_state == DRAIN && r_drain != 3'd0) r_drain <= r_drain - 3'd1;
        end
    end

    assign w_prod = (2*W)'(mul_a) * (2*W)'(mul_b);
    assign w_gold = PW'(w_prod);

    // Valid shift register; abort and start flush anything still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (abort || w_load) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_issue;
            for (int i = 1; i <= LAT; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // Golden product, operands and DUT product travel without reset
    always_ff @(posedge clk) begin
        r_gold[0] <= w_gold;
        r_opa[0]  <= mul_a;
        r_opb[0]  <= mul_b;
        for (int i = 1; i <= LAT; i++) begin
            r_gold[i] <= r_gold[i-1];
            r_opa[i]  <= r_opa[i-1];
            r_opb[i]  <= r_opb[i-1];
        end
        r_p <= mul_p;
    end

    assign w_chk = r_vld[LAT];
    assign w_mis = w_chk && (r_p != r_gold[LAT]);

    // Result counters; a check landing with abort is still counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
            r_fea      <= '0;
            r_feb      <= '0;
        end else if (w_load) begin
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
            r_fea      <= '0;
            r_feb      <= '0;
        end else if (w_chk) begin
            r_vec_cnt <= r_vec_cnt + NVEC_W'(1);
            if (w_mis) begin
                r_err_cnt  <= NVEC_W'(sat_inc(64'(r_err_cnt), CNT_MAX));
                r_err_flag <= 1'b1;
                if (!r_err_flag) begin
                    r_fea <= r_opa[LAT];
                    r_feb <= r_opb[LAT];
                end
            end
        end
    end

    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign vec_cnt     = r_vec_cnt;
    assign err_cnt     = r_err_cnt;
    assign err_flag    = r_err_flag;
    assign first_err_a = r_fea;
    assign first_err_b = r_feb;

endmodule

// File: tb/tb_mul_sweep_checker.sv
// Directed bench for mul_sweep_checker: several instances with different
// widths/latencies, each driven by a small behavioural multiplier model.
// The LFSR instance exists only when MULCHK_LFSR_EN is defined.
module tb_mul_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // u0: W=12, LAT=0, correct multiplier
    logic        st0 = 0;
    logic [15:0] nv0 = 0;
    logic [11:0] sa0 = 0, sb0 = 0, a0, b0, fa0, fb0;
    logic [24:0] p0;
    logic        busy0, done0, flag0;
    logic [15:0] vec0, err0;
    assign p0 = 25'(a0) * 25'(b0);

    mul_sweep_checker #(.W(12), .LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .abort(1'b0),
`ifdef MULCHK_LFSR_EN
        .mode(1'b0),
`endif
        .nvec(nv0), .step_a(sa0), .step_b(sb0), .mul_a(a0), .mul_b(b0), .mul_p(p0),
        .busy(busy0), .done(done0), .vec_cnt(vec0), .err_cnt(err0), .err_flag(flag0),
        .first_err_a(fa0), .first_err_b(fb0)
    );

    // u1: W=12, LAT=3, multiplier forces bit 0 high when a == 6
    logic        st1 = 0, ab1 = 0;
    logic [15:0] nv1 = 0;
    logic [11:0] sa1 = 0, sb1 = 0, a1, b1, fa1, fb1;
    logic [24:0] f1, d1_0, d1_1, d1_2;
    logic        busy1, done1, flag1;
    logic [15:0] vec1, err1;
    assign f1 = (25'(a1) * 25'(b1)) | 25'(a1 == 12'd6);
    always @(posedge clk) begin
        d1_0 <= f1;
        d1_1 <= d1_0;
        d1_2 <= d1_1;
    end

    mul_sweep_checker #(.W(12), .LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .abort(ab1),
`ifdef MULCHK_LFSR_EN
        .mode(1'b0),
`endif
        .nvec(nv1), .step_a(sa1), .step_b(sb1), .mul_a(a1), .mul_b(b1), .mul_p(d1_2),
        .busy(busy1), .done(done1), .vec_cnt(vec1), .err_cnt(err1), .err_flag(flag1),
        .first_err_a(fa1), .first_err_b(fb1)
    );

    // u2: W=4, LAT=0, correct multiplier
    logic        st2 = 0;
    logic [15:0] nv2 = 0;
    logic [3:0]  sa2 = 0, sb2 = 0, a2, b2, fa2, fb2;
    logic [8:0]  p2;
    logic        busy2, done2, flag2;
    logic [15:0] vec2, err2;
    assign p2 = 9'(a2) * 9'(b2);

    mul_sweep_checker #(.W(4), .LAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .abort(1'b0),
`ifdef MULCHK_LFSR_EN
        .mode(1'b0),
`endif
        .nvec(nv2), .step_a(sa2), .step_b(sb2), .mul_a(a2), .mul_b(b2), .mul_p(p2),
        .busy(busy2), .done(done2), .vec_cnt(vec2), .err_cnt(err2), .err_flag(flag2),
        .first_err_a(fa2), .first_err_b(fb2)
    );

`ifdef MULCHK_LFSR_EN
    // u3: W=8, LAT=0, LFSR operand mode
    logic        st3 = 0, md3 = 0;
    logic [15:0] nv3 = 0;
    logic [7:0]  sa3 = 0, sb3 = 0, a3, b3, fa3, fb3;
    logic [16:0] p3;
    logic        busy3, done3, flag3;
    logic [15:0] vec3, err3;
    assign p3 = 17'(a3) * 17'(b3);

    mul_sweep_checker #(.W(8), .LAT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .abort(1'b0), .mode(md3),
        .nvec(nv3), .step_a(sa3), .step_b(sb3), .mul_a(a3), .mul_b(b3), .mul_p(p3),
        .busy(busy3), .done(done3), .vec_cnt(vec3), .err_cnt(err3), .err_flag(flag3),
        .first_err_a(fa3), .first_err_b(fb3)
    );
`endif

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_busy0", busy0, 0);
        check_val("rst_done0", done0, 0);
        check_val("rst_a0", a0, 0);
        check_val("rst_vec0", vec0, 0);
        check_val("rst_flag1", flag1, 0);

        // Test 1: linear sweep 2k/k, 100 vectors, LAT=0
        nv0 = 16'd100; sa0 = 12'd2; sb0 = 12'd1;
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            check_val("t1_a", a0, 2 * (k - 1));
            check_val("t1_b", b0, k - 1);
            check_val("t1_busy", busy0, 1);
            @(negedge clk);
        end
        check_val("t1_drain_busy", busy0, 1);
        check_val("t1_drain_done", done0, 0);
        check_val("t1_hold_a", a0, 198);
        @(negedge clk);
        check_val("t1_done", done0, 1);
        check_val("t1_busy_off", busy0, 0);
        check_val("t1_vec", vec0, 100);
        check_val("t1_err", err0, 0);
        check_val("t1_flag", flag0, 0);

        // Test 2: LAT=3, faulty product when a == 6
        nv1 = 16'd10; sa1 = 12'd2; sb1 = 12'd1;
        st1 = 1'b1; @(negedge clk); st1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("t2_done_cycle", cyc, 15);
        check_val("t2_vec", vec1, 10);
        check_val("t2_err", err1, 1);
        check_val("t2_flag", flag1, 1);
        check_val("t2_fea", fa1, 6);
        check_val("t2_feb", fb1, 3);

        // Test 3: W=4 wrap-around, step_a=5, step_b=3
        nv2 = 16'd20; sa2 = 4'd5; sb2 = 4'd3;
        st2 = 1'b1; @(negedge clk); st2 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            check_val("t3_a", a2, (5 * (k - 1)) % 16);
            check_val("t3_b", b2, (3 * (k - 1)) % 16);
            @(negedge clk);
        end
        @(negedge clk);
        check_val("t3_done", done2, 1);
        check_val("t3_vec", vec2, 20);
        check_val("t3_err", err2, 0);

        // Test 4: free-run on u1, abort after 50 cycles
        nv1 = 16'd0; sa1 = 12'd2; sb1 = 12'd1;
        st1 = 1'b1; @(negedge clk); st1 = 1'b0;
        check_val("t4_flag_clr", flag1, 0);
        check_val("t4_err_clr", err1, 0);
        repeat (49) @(negedge clk);
        check_val("t4_busy_pre", busy1, 1);
        ab1 = 1'b1; @(negedge clk); ab1 = 1'b0;
        check_val("t4_busy", busy1, 0);
        check_val("t4_done", done1, 0);
        check_val("t4_vec", vec1, 46);
        check_val("t4_err", err1, 1);
        repeat (5) @(negedge clk);
        check_val("t4_vec_hold", vec1, 46);
        check_val("t4_idle", busy1, 0);

        // Test 5: async reset mid-RUN, then a clean sweep
        nv0 = 16'd100; sa0 = 12'd3; sb0 = 12'd1;
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t5_pre_vec", vec0, 9);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_rst_a", a0, 0);
        check_val("t5_rst_b", b0, 0);
        check_val("t5_rst_busy", busy0, 0);
        check_val("t5_rst_vec", vec0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nv0 = 16'd5; sa0 = 12'd2; sb0 = 12'd1;
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
        @(negedge clk);
        check_val("t5_a_k1", a0, 2);
        repeat (5) @(negedge clk);
        check_val("t5_done", done0, 1);
        check_val("t5_vec", vec0, 5);
        check_val("t5_err", err0, 0);

`ifdef MULCHK_LFSR_EN
        // Test 6: LFSR mode, W=8, 255 vectors with no repeats
        begin
            bit seen_a [256];
            bit seen_b [256];
            int uniq_a, uniq_b;
            uniq_a = 0; uniq_b = 0;
            nv3 = 16'd255; sa3 = 8'h5A; sb3 = 8'h33; md3 = 1'b1;
            st3 = 1'b1; @(negedge clk); st3 = 1'b0;
            check_val("t6_seed_a", a3, 8'h5B);
            check_val("t6_seed_b", b3, 8'h33);
            for (int k = 1; k <= 255; k++) begin
                if (k == 2) begin
                    check_val("t6_a2", a3, 8'h95);
                    check_val("t6_b2", b3, 8'hA1);
                end
                if (a3 != 0 && !seen_a[a3]) begin seen_a[a3] = 1'b1; uniq_a++; end
                if (b3 != 0 && !seen_b[b3]) begin seen_b[b3] = 1'b1; uniq_b++; end
                @(negedge clk);
            end
            cyc = 0;
            while (!done3 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check_val("t6_done", done3, 1);
            check_val("t6_uniq_a", uniq_a, 255);
            check_val("t6_uniq_b", uniq_b, 255);
            check_val("t6_vec", vec3, 255);
            check_val("t6_err", err3, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_sweep_checker.md
Name: mul_sweep_checker

Overview:
- Parametrised successor to the fixed 12x12 counter-driven multiplier harness.
- Generates operand sequences for an external W x W multiplier and captures its product after a configurable pipeline latency.
- Compares each captured product against an internal golden product and counts vectors and mismatches.
- Sits at the top level around any multiplier variant (Wallace, array, Booth) for on-chip/FPGA self-test.

Parameters:
- W, 12, operand width in bits (2..32).
- PW, 2*W+1, product port width; golden product zero-extended to PW.
- LAT, 0, DUT latency in cycles, 0..7; 0 = combinational DUT.
- NVEC_W, 16, width of vector count, target and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a sweep when IDLE or DONE.
- abort  in  1  returns to IDLE next cycle from any state.
- nvec  in  NVEC_W  vectors per sweep, sampled on start; 0 = free-run.
- step_a  in  W  increment for operand A.
- step_b  in  W  increment for operand B.
- mul_a  out  W  operand A to DUT.
- mul_b  out  W  operand B to DUT.
- mul_p  in  PW  DUT product.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- vec_cnt  out  NVEC_W  vectors checked.
- err_cnt  out  NVEC_W  mismatches, saturating.
- err_flag  out  1  sticky; set on first mismatch, cleared on start.
- first_err_a, first_err_b  out  W  operands of the first mismatch.

Behaviour:
- Reset (async assert, sync release): all outputs, counters and state are 0; FSM = IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start → RUN. mul_a = mul_b = 0; counters, err_flag and first_err_* cleared; nvec, step_a, step_b latched.
  - RUN: each cycle mul_a += step_a and mul_b += step_b, both mod 2^W (wrap-around silent). Issued count +1 per cycle.
  - RUN, when issued == nvec (nvec ≠ 0) → DRAIN. Operands hold their last value.
  - DRAIN: lasts LAT+1 cycles until every in-flight vector is checked → DONE. With LAT = 0, DRAIN lasts 1 cycle.
  - DONE: holds all results until the next start or abort.
  - abort has priority over start. abort clears busy only; counts are retained.
  - start while in RUN or DRAIN is ignored.
- Check pipeline:
  - valid bit and golden product {0, mul_a*mul_b} travel through a LAT+1 deep shift register.
  - mul_p is registered once, so the comparison occurs LAT+1 cycles after issue.
  - On valid: vec_cnt += 1. On mismatch: err_cnt += 1, saturating at all-ones.
  - first_err_a/b are captured only while err_flag is 0.
- Free-run (nvec = 0): stays in RUN until abort. vec_cnt wraps modulo 2^NVEC_W.
- Simultaneous mismatch and abort in the same cycle: the mismatch is still counted.

Optional Feature:
- MULCHK_LFSR_EN defined:
  - Adds input mode (1 bit), sampled on start.
  - mode = 1: mul_a and mul_b are driven from two independent maximal-length Galois LFSRs of width W. Seeds are step_a|1 and step_b|1.
  - mode = 0: linear stride, as above.
- MULCHK_LFSR_EN undefined: mode port absent; linear stride only.

Decomposition:
- Package mul_sweep_pkg holds:
  - FSM state enum (IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3).
  - Localparam table of LFSR tap masks indexed by W.
  - Saturating-increment function.
- Sub-module mul_sweep_opgen: operand generator (stride adder and LFSR), instantiated once per operand.

Test Plan:
- W = 12, LAT = 0, step_a = 2, step_b = 1, nvec = 100, correct DUT:
  - mul_a/mul_b equal 2k/k.
  - done after 102 cycles; vec_cnt = 100, err_cnt = 0.
- W = 12, LAT = 3, DUT forces bit 0 of p high when a = 6:
  - exactly 1 error; first_err_a = 6, first_err_b = 3; err_flag = 1.
- W = 4, step_a = 5, nvec = 20:
  - mul_a wraps 15→4; golden products match modulo wrap; err_cnt = 0.
- nvec = 0, abort after 50 cycles:
  - FSM returns to IDLE next cycle; busy = 0.
  - vec_cnt = 50 − LAT − 1 retained.
- rst_n asserted mid-RUN:
  - all outputs 0 immediately.
  - start after release gives a clean sweep.
- MULCHK_LFSR_EN, mode = 1, W = 8, nvec = 255:
  - operands take all 255 nonzero values with no repeat; err_cnt = 0.
